// File: rtl/serial_link_pkg.sv
// serial_link_pkg
//   Definitions shared by both ends of the single-wire serial link:
//   the frame-sequencer state encoding and the fixed line levels.
//   No ports (package).
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } link_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer
//   Divides the clock into serial bit periods of BIT_CYCLES clocks.
//   Ports:
//     clk      in   clock
//     rst      in   synchronous active-high reset
//     en       in   count while high; counter held at zero while low
//     bit_end  out  high on the last clock of each bit period
module serial_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cycle_cnt <= '0;
    end else if (cycle_cnt == LAST_CYCLE) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // With BIT_CYCLES=1 the counter sits at zero, so every enabled clock ends a bit.
  assign bit_end = en && (cycle_cnt == LAST_CYCLE);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-in, serial-out framed transmitter. Frame on sout:
//   start(0), WIDTH data bits LSB first, optional even parity, stop(1),
//   each bit held for BIT_CYCLES clocks.
//   Ports:
//     clk       in   clock
//     rst       in   synchronous active-high reset (aborts any frame)
//     tx_data   in   word to send, sampled on the accept edge only
//     tx_valid  in   producer has a word
//     tx_ready  out  block can accept (IDLE and not in reset)
//     sout      out  registered serial line, idles high
//     busy      out  frame in progress (START..STOP)
//     done      out  one-cycle pulse on the first IDLE cycle after a frame
//
//   state  | meaning
//   IDLE   | line high, waiting for tx_valid
//   START  | driving the start bit
//   DATA   | shifting out data bits, LSB first
//   PARITY | driving the latched even-parity bit
//   STOP   | driving the stop bit
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  import serial_link_pkg::*;

  localparam int BCW = $clog2(WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  link_state_t      state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic             parity_q, parity_nxt;
  logic             sout_nxt;
  logic             done_nxt;
  logic             timer_en;
  logic             bit_end;

  assign timer_en = (state != IDLE);

  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .bit_end(bit_end)
  );

  assign tx_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      parity_q  <= 1'b0;
      sout      <= IDLE_LEVEL;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      parity_q  <= parity_nxt;
      sout      <= sout_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    parity_nxt  = parity_q;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_nxt  = START;
          shift_nxt  = tx_data;
          parity_nxt = ^tx_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sout is registered, so it is decoded from the state being entered;
  // this puts the start bit on the wire the cycle right after accept.
  always_comb begin
    sout_nxt = IDLE_LEVEL;
    case (state_nxt)
      IDLE:    sout_nxt = IDLE_LEVEL;
      START:   sout_nxt = START_BIT;
      DATA:    sout_nxt = shift_nxt[0];
      PARITY:  sout_nxt = parity_nxt;
      STOP:    sout_nxt = STOP_BIT;
      default: sout_nxt = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
//   Three transmitter instances (8-bit data):
//     0: BIT_CYCLES=1, no parity   1: BIT_CYCLES=1, parity   2: BIT_CYCLES=4, no parity
//   Expected frames are written in wire order (bit i = i-th bit on sout)
//   and queued per instance; a per-instance monitor follows each frame.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v      [3];
  logic       tx_valid_v [3];
  logic [7:0] tx_data_v  [3];
  logic       tx_ready_v [3];
  logic       sout_v     [3];
  logic       busy_v     [3];
  logic       done_v     [3];

  logic [10:0] exp_q [3][$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int BC = (g == 2) ? 4 : 1;
    localparam int PE = (g == 1) ? 1 : 0;
    localparam int NB = 10 + PE;

    serial_frame_tx #(
      .WIDTH     (8),
      .BIT_CYCLES(BC),
      .PARITY_EN (PE)
    ) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .tx_data (tx_data_v[g]),
      .tx_valid(tx_valid_v[g]),
      .tx_ready(tx_ready_v[g]),
      .sout    (sout_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g])
    );

    logic [10:0] cur = '0;
    int pos = 0;
    bit cap = 1'b0;
    bit exp_done = 1'b0;
    bit prev_busy = 1'b0;
    bit chk_idle = 1'b0;

    always @(negedge clk) begin
      if (mon_en) begin
        if (rst_v[g] === 1'b1) begin
          cap = 1'b0;
          exp_done = 1'b0;
          chk_idle = 1'b1;
          prev_busy = 1'b0;
        end else begin
          if (chk_idle) begin
            chk($sformatf("i%0d_abort_idle", g), sout_v[g], 1'b1);
            chk_idle = 1'b0;
          end
          chk($sformatf("i%0d_done", g), done_v[g], exp_done);
          if (exp_done) chk($sformatf("i%0d_busy_after", g), busy_v[g], 1'b0);
          exp_done = 1'b0;
          if (!cap && busy_v[g] === 1'b1 && !prev_busy) begin
            chk($sformatf("i%0d_frame_expected", g), (exp_q[g].size() != 0), 1'b1);
            if (exp_q[g].size() != 0) begin
              cur = exp_q[g].pop_front();
              cap = 1'b1;
              pos = 0;
            end
          end
          if (cap) begin
            chk($sformatf("i%0d_sout_c%0d", g, pos), sout_v[g], cur[pos / BC]);
            chk($sformatf("i%0d_busy_c%0d", g, pos), busy_v[g], 1'b1);
            pos++;
            if (pos == NB * BC) begin
              cap = 1'b0;
              exp_done = 1'b1;
            end
          end
          prev_busy = (busy_v[g] === 1'b1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int g, input logic [7:0] d, input logic [10:0] frame);
    int t = 0;
    while (tx_ready_v[g] !== 1'b1 && t < 200) begin
      tick(1);
      t++;
    end
    chk($sformatf("i%0d_ready_wait", g), tx_ready_v[g], 1'b1);
    tx_valid_v[g] = 1'b1;
    tx_data_v[g]  = d;
    exp_q[g].push_back(frame);
    tick(1);
    tx_valid_v[g] = 1'b0;
    tx_data_v[g]  = ~d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      rst_v[i]      = 1'b1;
      tx_valid_v[i] = 1'b1;
      tx_data_v[i]  = 8'h5A;
    end

    // reset held 3 clocks with tx_valid high: nothing may start
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_rst_sout", i), sout_v[i], 1'b1);
        chk($sformatf("i%0d_rst_busy", i), busy_v[i], 1'b0);
        chk($sformatf("i%0d_rst_done", i), done_v[i], 1'b0);
        chk($sformatf("i%0d_rst_ready", i), tx_ready_v[i], 1'b0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      rst_v[i]      = 1'b0;
      tx_valid_v[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_rel_ready", i), tx_ready_v[i], 1'b1);
      chk($sformatf("i%0d_rel_busy", i), busy_v[i], 1'b0);
      chk($sformatf("i%0d_rel_sout", i), sout_v[i], 1'b1);
    end
    mon_en = 1'b1;
    tick(1);

    // single frame A5: wire 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, 11'b0_1_10100101_0);
    tick(14);

    // even parity: A5 has four ones -> 0, A4 has three -> 1
    send(1, 8'hA5, 11'b1_0_10100101_0);
    tick(14);
    send(1, 8'hA4, 11'b1_1_10100100_0);
    tick(14);

    // stretched bits; tx_valid pulses while busy must be ignored
    send(2, 8'h01, 11'b0_1_00000001_0);
    tx_valid_v[2] = 1'b1;
    tx_data_v[2]  = 8'hFF;
    tick(10);
    tx_valid_v[2] = 1'b0;
    tick(36);

    // back-to-back with tx_valid held high
    tx_valid_v[0] = 1'b1;
    tx_data_v[0]  = 8'h3C;
    exp_q[0].push_back(11'b0_1_00111100_0);
    tick(1);
    tx_data_v[0] = 8'hC3;
    exp_q[0].push_back(11'b0_1_11000011_0);
    t = 0;
    while (done_v[0] !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    chk("b2b_done_seen", done_v[0], 1'b1);
    chk("b2b_ready_in_done", tx_ready_v[0], 1'b1);
    chk("b2b_gap_sout", sout_v[0], 1'b1);
    tick(1);
    chk("b2b_start_busy", busy_v[0], 1'b1);
    chk("b2b_start_low", sout_v[0], 1'b0);
    tx_valid_v[0] = 1'b0;
    tx_data_v[0]  = 8'h00;
    tick(14);

    // reset during DATA bit 3 of FF, then a fresh frame
    send(0, 8'hFF, 11'b0_1_11111111_0);
    tick(4);
    rst_v[0] = 1'b1;
    tick(1);
    rst_v[0] = 1'b0;
    chk("abort_sout_high", sout_v[0], 1'b1);
    chk("abort_busy_low", busy_v[0], 1'b0);
    chk("abort_no_done", done_v[0], 1'b0);
    tick(3);
    chk("abort_still_idle", busy_v[0], 1'b0);
    send(0, 8'h81, 11'b0_1_10000001_0);
    tick(14);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_queue_drained", i), exp_q[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
